// File: rtl/bin2seg_converter_if.sv
// Request/result bundle between the counter side and the BCD/seven-segment converter.
interface bin2seg_converter_if;
   logic       START;
   logic [7:0] BIN;
   logic       BUSY;
   logic       DONE;
   logic [11:0] BCD;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;

   modport master (output START, BIN, input BUSY, DONE, BCD, HEX0, HEX1, HEX2);
   modport slave  (input START, BIN, output BUSY, DONE, BCD, HEX0, HEX1, HEX2);
endinterface

// File: rtl/bin2seg_converter.sv
// 8-bit binary to 3-digit BCD (8-step double-dabble) with registered active-low 7-seg digits.
// Define LEADING_ZERO_BLANK_EN to blank leading-zero hundreds/tens digits.
module bin2seg_converter (
   input  logic               CLK,
   input  logic               RST,
   bin2seg_converter_if.slave bus
);
   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [6:0] SEG_ZERO  = 7'h40;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] HEX_UPPER_RST = SEG_BLANK;
`else
   localparam logic [6:0] HEX_UPPER_RST = SEG_ZERO;
`endif

   state_t      state_q, state_d;
   logic [19:0] scratch_q, scratch_d;
   logic [19:0] adj;
   logic [2:0]  step_q, step_d;
   logic [11:0] bcd_q, bcd_d;
   logic [6:0]  hex0_q, hex0_d;
   logic [6:0]  hex1_q, hex1_d;
   logic [6:0]  hex2_q, hex2_d;
   logic        done_q, done_d;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    seg7 = 7'h40;
         4'd1:    seg7 = 7'h79;
         4'd2:    seg7 = 7'h24;
         4'd3:    seg7 = 7'h30;
         4'd4:    seg7 = 7'h19;
         4'd5:    seg7 = 7'h12;
         4'd6:    seg7 = 7'h02;
         4'd7:    seg7 = 7'h78;
         4'd8:    seg7 = 7'h00;
         4'd9:    seg7 = 7'h10;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] v);
      add3 = (v >= 4'd5) ? v + 4'd3 : v;
   endfunction

   always_comb begin
      adj       = {add3(scratch_q[19:16]), add3(scratch_q[15:12]),
                   add3(scratch_q[11:8]), scratch_q[7:0]};
      state_d   = state_q;
      scratch_d = scratch_q;
      step_d    = step_q;
      bcd_d     = bcd_q;
      hex0_d    = hex0_q;
      hex1_d    = hex1_q;
      hex2_d    = hex2_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.START) begin
               scratch_d = {12'h000, bus.BIN};
               step_d    = 3'd0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adj[18:0], 1'b0};
            step_d    = step_q + 3'd1;
            if (step_q == 3'd7) begin
               bcd_d   = scratch_d[19:8];
               hex0_d  = seg7(scratch_d[11:8]);
               hex1_d  = seg7(scratch_d[15:12]);
               hex2_d  = seg7(scratch_d[19:16]);
`ifdef LEADING_ZERO_BLANK_EN
               // A zero tens digit is only a leading zero when hundreds is also zero.
               if (scratch_d[19:16] == 4'd0) begin
                  hex2_d = SEG_BLANK;
                  if (scratch_d[15:12] == 4'd0)
                     hex1_d = SEG_BLANK;
               end
`endif
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         scratch_q <= 20'h00000;
         step_q    <= 3'd0;
         bcd_q     <= 12'h000;
         hex0_q    <= SEG_ZERO;
         hex1_q    <= HEX_UPPER_RST;
         hex2_q    <= HEX_UPPER_RST;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         scratch_q <= scratch_d;
         step_q    <= step_d;
         bcd_q     <= bcd_d;
         hex0_q    <= hex0_d;
         hex1_q    <= hex1_d;
         hex2_q    <= hex2_d;
         done_q    <= done_d;
      end
   end

   assign bus.BUSY = (state_q == SHIFT);
   assign bus.DONE = done_q;
   assign bus.BCD  = bcd_q;
   assign bus.HEX0 = hex0_q;
   assign bus.HEX1 = hex1_q;
   assign bus.HEX2 = hex2_q;
endmodule

// File: tb/tb_bin2seg_converter.sv
// Directed bench for bin2seg_converter: vector table plus abort/overlap/back-to-back sequences.
module tb_bin2seg_converter;
   logic CLK = 1'b0;
   logic RST;

   bin2seg_converter_if bus();
   bin2seg_converter dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = 7'h7F;
`else
   localparam logic [6:0] LZ = 7'h40;
`endif

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] bcd;
      logic [6:0]  h2;
      logic [6:0]  h1;
      logic [6:0]  h0;
   } vec_t;

   vec_t vecs [10];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issues one request, scrambles BIN once accepted, returns cycles from acceptance to DONE.
   task automatic convert(input logic [7:0] b, output int lat);
      @(negedge CLK);
      bus.START = 1'b1;
      bus.BIN   = b;
      @(negedge CLK);
      bus.START = 1'b0;
      bus.BIN   = ~b;
      check("busy_after_accept", {31'd0, bus.BUSY}, 32'd1);
      lat = 0;
      while (!bus.DONE && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int ndone;
      int last_done;
      logic [6:0] exp_h0;

      vecs[0] = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12};
      vecs[1] = '{8'd100, 12'h100, 7'h79, 7'h40, 7'h40};
      vecs[2] = '{8'd7,   12'h007, LZ,    LZ,    7'h78};
      vecs[3] = '{8'd0,   12'h000, LZ,    LZ,    7'h40};
      vecs[4] = '{8'd9,   12'h009, LZ,    LZ,    7'h10};
      vecs[5] = '{8'd10,  12'h010, LZ,    7'h79, 7'h40};
      vecs[6] = '{8'd42,  12'h042, LZ,    7'h19, 7'h24};
      vecs[7] = '{8'd99,  12'h099, LZ,    7'h10, 7'h10};
      vecs[8] = '{8'd200, 12'h200, 7'h24, 7'h40, 7'h40};
      vecs[9] = '{8'd128, 12'h128, 7'h79, 7'h24, 7'h00};

      RST = 1'b1;
      bus.START = 1'b0;
      bus.BIN = 8'd0;
      repeat (3) @(negedge CLK);
      check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
      check("rst_done", {31'd0, bus.DONE}, 32'd0);
      check("rst_bcd",  {20'd0, bus.BCD}, 32'h000);
      check("rst_hex0", {25'd0, bus.HEX0}, 32'h40);
      check("rst_hex1", {25'd0, bus.HEX1}, {25'd0, LZ});
      check("rst_hex2", {25'd0, bus.HEX2}, {25'd0, LZ});
      RST = 1'b0;

      for (int i = 0; i < 10; i++) begin
         convert(vecs[i].bin, lat);
         check("latency", lat, 32'd8);
         check("bcd",  {20'd0, bus.BCD},  {20'd0, vecs[i].bcd});
         check("hex2", {25'd0, bus.HEX2}, {25'd0, vecs[i].h2});
         check("hex1", {25'd0, bus.HEX1}, {25'd0, vecs[i].h1});
         check("hex0", {25'd0, bus.HEX0}, {25'd0, vecs[i].h0});
         check("busy_at_done", {31'd0, bus.BUSY}, 32'd0);
         @(negedge CLK);
         check("done_one_cycle", {31'd0, bus.DONE}, 32'd0);
         check("bcd_hold", {20'd0, bus.BCD}, {20'd0, vecs[i].bcd});
      end

      // START during SHIFT is dropped: only the first request completes.
      @(negedge CLK);
      bus.START = 1'b1;
      bus.BIN = 8'd42;
      @(negedge CLK);
      bus.START = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         bus.START = (c == 3);
         bus.BIN = (c == 3) ? 8'd99 : 8'd0;
         @(negedge CLK);
         if (bus.DONE) ndone++;
      end
      bus.START = 1'b0;
      check("overlap_done_count", ndone, 32'd1);
      check("overlap_bcd", {20'd0, bus.BCD}, 32'h042);

      // START held high: each request is accepted in the idle cycle that shows DONE,
      // so completions are 9 edges apart (8 busy + 1 idle accept).
      @(negedge CLK);
      bus.START = 1'b1;
      bus.BIN = 8'd9;
      exp_h0 = 7'h10;
      ndone = 0;
      last_done = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         if (bus.DONE) begin
            ndone++;
            check("b2b_hex0", {25'd0, bus.HEX0}, {25'd0, exp_h0});
            if (ndone > 1) check("b2b_spacing", c - last_done, 32'd9);
            last_done = c;
            bus.BIN = (bus.BIN == 8'd9) ? 8'd10 : 8'd9;
            exp_h0 = (exp_h0 == 7'h10) ? 7'h40 : 7'h10;
         end
      end
      check("b2b_done_count", ndone, 32'd4);
      bus.START = 1'b0;
      lat = 0;
      while (bus.BUSY && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      check("b2b_drain", {31'd0, bus.BUSY}, 32'd0);

      // Reset on SHIFT cycle 4 aborts the conversion and clears outputs.
      @(negedge CLK);
      bus.START = 1'b1;
      bus.BIN = 8'd200;
      @(negedge CLK);
      bus.START = 1'b0;
      repeat (3) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort_busy", {31'd0, bus.BUSY}, 32'd0);
      check("abort_done", {31'd0, bus.DONE}, 32'd0);
      check("abort_bcd",  {20'd0, bus.BCD}, 32'h000);
      check("abort_hex0", {25'd0, bus.HEX0}, 32'h40);
      check("abort_hex1", {25'd0, bus.HEX1}, {25'd0, LZ});
      check("abort_hex2", {25'd0, bus.HEX2}, {25'd0, LZ});
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge CLK);
         if (bus.DONE) ndone++;
      end
      check("abort_no_done", ndone, 32'd0);
      convert(8'd200, lat);
      check("after_abort_latency", lat, 32'd8);
      check("after_abort_bcd", {20'd0, bus.BCD}, 32'h200);

      // Reset wins over a simultaneous START.
      @(negedge CLK);
      RST = 1'b1;
      bus.START = 1'b1;
      bus.BIN = 8'd5;
      @(negedge CLK);
      RST = 1'b0;
      bus.START = 1'b0;
      check("rst_prio_busy", {31'd0, bus.BUSY}, 32'd0);
      check("rst_prio_bcd", {20'd0, bus.BCD}, 32'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
